// File: rtl/lookup_pkg.sv
// Shared types and constants for the MAC lookup arbiter: FSM encoding,
// lookup tag format, seek_flag codes and bus widths.
package lookup_pkg;

    localparam int MAC_W  = 48;
    localparam int TAG_W  = 4;
    localparam int PORT_W = 3;
    localparam int SEEK_W = 2;
    localparam int IDX_W  = 3;

    // The engine only latches check inputs when the tag is nonzero, so every tag carries this prefix
    localparam logic TAG_PREFIX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [SEEK_W-1:0] {
        SEEK_DDR    = 2'd0,
        SEEK_XBAR   = 2'd1,
        SEEK_TWOHOP = 2'd2,
        SEEK_VLB    = 2'd3
    } seek_t;

    function automatic logic [TAG_W-1:0] make_tag(input logic [IDX_W-1:0] idx);
        return {TAG_PREFIX, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from a rotating pointer with wrap and
// moves the pointer just past the winner whenever i_advance is strobed.
module rr_arbiter
    import lookup_pkg::*;
#(
    parameter int P_REQ_NUM = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [P_REQ_NUM-1:0] i_req,
    input  logic                 i_advance,
    output logic [P_REQ_NUM-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_REQ_NUM - 1);

    logic [IDX_W-1:0]     r_ptr;
    logic [P_REQ_NUM-1:0] w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_found;

    always_comb begin : p_search
        int k;
        k       = 0;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < P_REQ_NUM; i++) begin
            k = int'(r_ptr) + i;
            if (k >= P_REQ_NUM) begin
                k = k - P_REQ_NUM;
            end
            if (!w_found && i_req[k]) begin
                w_found    = 1'b1;
                w_grant[k] = 1'b1;
                w_idx      = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;

endmodule

// File: rtl/lookup_arbiter.sv
// Shares one MAC lookup engine among up to 8 requesters, one lookup in flight.
// Define LKUP_TIMEOUT_EN to abandon lookups after P_TIMEOUT cycles in WAIT.
module lookup_arbiter
    import lookup_pkg::*;
#(
    parameter int P_REQ_NUM = 4,
    parameter int P_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [P_REQ_NUM-1:0]       i_req_valid,
    input  logic [MAC_W*P_REQ_NUM-1:0] i_req_mac,
    output logic [P_REQ_NUM-1:0]       o_req_ready,
    output logic [MAC_W-1:0]           o_check_mac,
    output logic [TAG_W-1:0]           o_check_id,
    output logic                       o_check_valid,
    input  logic                       i_result_valid,
    input  logic [TAG_W-1:0]           i_check_id,
    input  logic [PORT_W-1:0]          i_outport,
    input  logic [SEEK_W-1:0]          i_seek_flag,
    output logic [P_REQ_NUM-1:0]       o_rsp_valid,
    output logic [PORT_W-1:0]          o_rsp_outport,
    output logic [SEEK_W-1:0]          o_rsp_seek_flag,
    output logic                       o_rsp_timeout
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [P_REQ_NUM-1:0] r_req_ready;
    logic [MAC_W-1:0]     r_check_mac;
    logic [TAG_W-1:0]     r_check_id;
    logic                 r_check_valid;
    logic [P_REQ_NUM-1:0] r_rsp_valid;
    logic [PORT_W-1:0]    r_rsp_outport;
    logic [SEEK_W-1:0]    r_rsp_seek_flag;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [P_REQ_NUM-1:0] r_owner;
    logic [MAC_W-1:0]     r_mac;

    logic [P_REQ_NUM-1:0] w_grant;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [MAC_W-1:0]     w_sel_mac;
    logic                 w_any_req;
    logic                 w_hit;
    logic                 w_expire;
    logic                 w_advance;
    logic                 w_latch;
    logic                 w_issue;
    logic                 w_rsp_load;
    logic                 w_rsp_timeout;

    assign w_any_req = |i_req_valid;
    assign w_hit     = (r_state == ST_WAIT) && i_result_valid && (i_check_id == r_check_id);

    rr_arbiter #(
        .P_REQ_NUM(P_REQ_NUM)
    ) u_rr_arbiter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req_valid),
        .i_advance(w_advance),
        .o_grant  (w_grant),
        .o_idx    (w_gnt_idx)
    );

    always_comb begin
        w_sel_mac = '0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            if (w_grant[k]) begin
                w_sel_mac = i_req_mac[k*MAC_W +: MAC_W];
            end
        end
    end

`ifdef LKUP_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(P_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // A matching result in the expiry cycle takes precedence over the timeout
    assign w_expire = (r_state == ST_WAIT) && (r_wait_cnt == CNT_LAST) && !w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_rsp_load && w_rsp_timeout;
        end
    end

    assign o_rsp_timeout = r_rsp_timeout;
`else
    assign w_expire      = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_hit || w_expire) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_advance     = 1'b0;
        w_latch       = 1'b0;
        w_issue       = 1'b0;
        w_rsp_load    = 1'b0;
        w_rsp_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_advance = 1'b1;
                    w_latch   = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
            end
            ST_WAIT: begin
                if (w_hit) begin
                    w_rsp_load = 1'b1;
                end else if (w_expire) begin
                    w_rsp_load    = 1'b1;
                    w_rsp_timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Check tag and MAC are only reloaded at issue so the engine sees a stable nonzero tag afterwards
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_ready     <= '0;
            r_check_mac     <= '0;
            r_check_id      <= '0;
            r_check_valid   <= 1'b0;
            r_rsp_valid     <= '0;
            r_rsp_outport   <= '0;
            r_rsp_seek_flag <= '0;
            r_gnt_idx       <= '0;
            r_owner         <= '0;
            r_mac           <= '0;
        end else begin
            r_req_ready   <= w_latch ? w_grant : '0;
            r_check_valid <= w_issue;
            r_rsp_valid   <= w_rsp_load ? r_owner : '0;
            if (w_latch) begin
                r_gnt_idx <= w_gnt_idx;
                r_owner   <= w_grant;
                r_mac     <= w_sel_mac;
            end
            if (w_issue) begin
                r_check_id  <= make_tag(r_gnt_idx);
                r_check_mac <= r_mac;
            end
            if (w_rsp_load) begin
                r_rsp_outport   <= w_rsp_timeout ? '0 : i_outport;
                r_rsp_seek_flag <= w_rsp_timeout ? SEEK_DDR : i_seek_flag;
            end
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_check_mac     = r_check_mac;
    assign o_check_id      = r_check_id;
    assign o_check_valid   = r_check_valid;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_outport   = r_rsp_outport;
    assign o_rsp_seek_flag = r_rsp_seek_flag;

endmodule
